// File: rtl/param_ram.sv
// param_ram: single-port byte-lane-writable RAM with a registered read port.
// After reset (or a clr request) the array is swept to zero one word per
// cycle; accesses arriving during the sweep are dropped and flagged on rej.
module param_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic                  clr,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  ready,
  output logic                  rej
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Control FSM: clear sweep sequencing, registered read data and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      ptr        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ready      <= 1'b0;
      rej        <= 1'b0;
    end else begin
      dout       <= '0;
      dout_valid <= 1'b0;
      rej        <= 1'b0;
      case (state)
        INIT: begin
          // clr is ignored here; the sweep always runs its full length
          rej <= cen;
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (cen && !wen) begin
            dout       <= mem[addr];
            dout_valid <= 1'b1;
          end
          // the access presented alongside clr is still carried out
          if (clr) begin
            state <= INIT;
            ptr   <= '0;
            ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage: zero fill during the sweep, byte-lane masked writes when running
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[ptr] <= '0;
    end else if (cen && wen) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
      end
    end
  end

endmodule
